// File: rtl/gb_cart_pkg.sv
// gb_cart_pkg: shared constants and types
// for the MBC1 cartridge responder.
package gb_cart_pkg;

  localparam logic [15:0] ROM0_HI = 16'h3FFF;
  localparam logic [15:0] ROMX_HI = 16'h7FFF;
  localparam logic [15:0] CRAM_LO = 16'hA000;
  localparam logic [15:0] CRAM_HI = 16'hBFFF;

  localparam logic [3:0] RAMG_KEY = 4'hA;

  localparam logic [4:0] BANK1_RST = 5'd1;
  localparam logic [1:0] BANK2_RST = 2'd0;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    PEND
  } state_t;

endpackage

// File: rtl/cart_mbc1_if.sv
// cart_mbc1_if: request/ack bus between the
// mapper and the ROM/RAM backing store.
interface cart_mbc1_if #(
  parameter int ROM_AW = 20
);
  logic              mem_req;
  logic              mem_we;
  logic              mem_ram;
  logic [ROM_AW-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_ram,
    output mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_ram,
    input  mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mbc1_bank_regs.sv
// mbc1_bank_regs: MBC1 control registers and
// CPU-to-backing-store address translation.
module mbc1_bank_regs
  import gb_cart_pkg::*;
#(
  parameter int ROM_AW = 20,
  parameter int RAM_AW = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [14:0]       addr,
  input  logic [4:0]        di,
  input  logic [ROM_AW-15:0] rom_mask,
  input  logic [RAM_AW-14:0] ram_mask,
  output logic              ram_en,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [RAM_AW-1:0] ram_addr
);

  logic [4:0] bank1;
  logic [1:0] bank2;
  logic       mode;
  logic [6:0] bank;
  logic [1:0] rbank;

  // register file, written by CPU stores to 0x0000-0x7FFF
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_en <= 1'b0;
      bank1  <= BANK1_RST;
      bank2  <= BANK2_RST;
      mode   <= 1'b0;
    end else if (we) begin
      unique case (addr[14:13])
        2'd0: ram_en <= (di[3:0] == RAMG_KEY);
        2'd1: bank1  <= (di == 5'd0) ? 5'd1 : di;
        2'd2: bank2  <= di[1:0];
        default: mode <= di[0];
      endcase
    end
  end

  // bank selection and flat address formation
  always_comb begin
    if ({1'b0, addr} <= ROM0_HI)
      bank = mode ? {bank2, 5'd0} : 7'd0;
    else
      bank = {bank2, bank1};
    rbank = mode ? bank2 : 2'd0;
    rom_addr = ROM_AW'({bank & 7'(rom_mask), addr[13:0]});
    ram_addr = RAM_AW'({rbank & 2'(ram_mask), addr[12:0]});
  end

endmodule

// File: rtl/cart_mbc1.sv
// cart_mbc1: MBC1 cartridge responder with
// trigger detection and a one-deep request slot.
module cart_mbc1
  import gb_cart_pkg::*;
#(
  parameter int ROM_AW = 20,
  parameter int RAM_AW = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ROM_AW-15:0] rom_mask,
  input  logic [RAM_AW-14:0] ram_mask,
  input  logic [15:0]        cart_addr,
  input  logic               cart_rd,
  input  logic               cart_wr,
  input  logic [7:0]         cart_di,
  output logic [7:0]         cart_do,
  cart_mbc1_if.master        mem,
  output logic               sav_dirty
);

  typedef struct packed {
    logic              we;
    logic              ram;
    logic [ROM_AW-1:0] addr;
    logic [7:0]        wdata;
  } req_t;

  logic        prev_rd;
  logic        prev_wr;
  logic [15:0] prev_addr;

  logic rd_trig;
  logic wr_trig;
  logic in_rom;
  logic in_cram;
  logic reg_we;
  logic mem_trig;
  logic ff_rd;
  logic ram_en;

  logic [ROM_AW-1:0] rom_addr;
  logic [RAM_AW-1:0] ram_addr;

  req_t   nreq;
  req_t   cur;
  req_t   pend;
  logic   pend_vld;
  state_t state;

  mbc1_bank_regs #(
    .ROM_AW(ROM_AW),
    .RAM_AW(RAM_AW)
  ) u_regs (
    .clk      (clk),
    .reset    (reset),
    .we       (reg_we),
    .addr     (cart_addr[14:0]),
    .di       (cart_di[4:0]),
    .rom_mask (rom_mask),
    .ram_mask (ram_mask),
    .ram_en   (ram_en),
    .rom_addr (rom_addr),
    .ram_addr (ram_addr)
  );

  // previous-cycle strobes for edge/change detection
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_rd   <= 1'b0;
      prev_wr   <= 1'b0;
      prev_addr <= 16'h0000;
    end else begin
      prev_rd   <= cart_rd;
      prev_wr   <= cart_wr;
      prev_addr <= cart_addr;
    end
  end

  // trigger decode and snapshot of the next request
  always_comb begin
    in_rom   = (cart_addr <= ROMX_HI);
    in_cram  = (cart_addr >= CRAM_LO) &&
               (cart_addr <= CRAM_HI);
    wr_trig  = cart_wr && !prev_wr;
    rd_trig  = cart_rd && !wr_trig &&
               (!prev_rd || (cart_addr != prev_addr));
    reg_we   = wr_trig && in_rom;
    mem_trig = (rd_trig && in_rom) ||
               (in_cram && ram_en && (rd_trig || wr_trig));
    ff_rd    = rd_trig && in_cram && !ram_en;
    nreq.we    = wr_trig;
    nreq.ram   = in_cram;
    nreq.addr  = in_cram ? ROM_AW'(ram_addr) : rom_addr;
    nreq.wdata = cart_di;
  end

  assign mem.mem_we    = cur.we;
  assign mem.mem_ram   = cur.ram;
  assign mem.mem_addr  = cur.addr;
  assign mem.mem_wdata = cur.wdata;

  // request FSM, pending slot and read-data register
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mem.mem_req <= 1'b0;
      cur         <= '0;
      pend        <= '0;
      pend_vld    <= 1'b0;
      cart_do     <= 8'hFF;
      sav_dirty   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_trig) begin
            cur         <= nreq;
            mem.mem_req <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            if (!cur.we)
              cart_do <= mem.mem_rdata;
            if (cur.we && cur.ram)
              sav_dirty <= 1'b1;
            state <= (pend_vld || mem_trig) ? PEND : IDLE;
          end
          if (mem_trig) begin
            pend     <= nreq;
            pend_vld <= 1'b1;
          end
        end
        PEND: begin
          cur         <= pend;
          mem.mem_req <= 1'b1;
          state       <= REQ;
          pend_vld    <= mem_trig;
          if (mem_trig)
            pend <= nreq;
        end
        default: state <= IDLE;
      endcase
      if (ff_rd)
        cart_do <= 8'hFF;
    end
  end

endmodule
